// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_bus_arbiter
// Brief   : Round-robin two-master / one-slave bus arbiter with registered
//           slave request, req/ack wait states and hung-access timeout.
// Revision: 1.0
// ============================================================================
module mem_bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_m0_req,
   input  logic              i_m0_we,
   input  logic [ADDR_W-1:0] i_m0_addr,
   input  logic [DATA_W-1:0] i_m0_wdata,
   input  logic [1:0]        i_m0_size,
   output logic              o_m0_ack,
   output logic              o_m0_err,
   output logic [DATA_W-1:0] o_m0_rdata,
   input  logic              i_m1_req,
   input  logic              i_m1_we,
   input  logic [ADDR_W-1:0] i_m1_addr,
   input  logic [DATA_W-1:0] i_m1_wdata,
   input  logic [1:0]        i_m1_size,
   output logic              o_m1_ack,
   output logic              o_m1_err,
   output logic [DATA_W-1:0] o_m1_rdata,
   output logic              o_s_req,
   output logic              o_s_we,
   output logic [ADDR_W-1:0] o_s_addr,
   output logic [DATA_W-1:0] o_s_wdata,
   output logic [1:0]        o_s_size,
   input  logic              i_s_ack,
   input  logic [DATA_W-1:0] i_s_rdata,
   output logic              o_busy,
   output logic              o_owner
);

   localparam int                c_cnt_w    = $clog2(TIMEOUT + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                w_grant;
   logic                w_sel;
   logic                w_cnt_last;
   logic                r_owner;
   logic                r_rr_last;
   logic                r_s_we;
   logic [ADDR_W-1:0]   r_s_addr;
   logic [DATA_W-1:0]   r_s_wdata;
   logic [1:0]          r_s_size;
   logic [c_cnt_w-1:0]  r_cnt;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_err;
   logic                w_m0_ack;
   logic                w_m1_ack;

   assign w_cnt_last = (r_cnt == c_cnt_last);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // On a tie the master that was not served last wins.
   always_comb begin
      w_state_next = r_state;
      w_grant      = 1'b0;
      w_sel        = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_m0_req || i_m1_req) begin
               w_grant      = 1'b1;
               w_sel        = (i_m0_req && i_m1_req) ? ~r_rr_last : i_m1_req;
               w_state_next = ACCESS;
            end
         end
         ACCESS: begin
            if (i_s_ack || w_cnt_last) begin
               w_state_next = RESP;
            end
         end
         RESP:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_owner   <= 1'b0;
         r_rr_last <= 1'b1;
         r_s_we    <= 1'b0;
         r_s_addr  <= '0;
         r_s_wdata <= '0;
         r_s_size  <= '0;
         r_cnt     <= '0;
         r_rdata   <= '0;
         r_err     <= 1'b0;
      end else begin
         if (w_grant) begin
            r_owner   <= w_sel;
            r_s_we    <= w_sel ? i_m1_we    : i_m0_we;
            r_s_addr  <= w_sel ? i_m1_addr  : i_m0_addr;
            r_s_wdata <= w_sel ? i_m1_wdata : i_m0_wdata;
            r_s_size  <= w_sel ? i_m1_size  : i_m0_size;
            r_cnt     <= '0;
         end
         // An ack arriving in the last allowed cycle still beats the timeout.
         if (r_state == ACCESS) begin
            if (i_s_ack) begin
               r_rdata <= i_s_rdata;
               r_err   <= 1'b0;
            end else if (w_cnt_last) begin
               r_rdata <= '0;
               r_err   <= 1'b1;
            end else begin
               r_cnt <= r_cnt + c_cnt_w'(1);
            end
         end
         if (r_state == RESP) begin
            r_rr_last <= r_owner;
         end
      end
   end

   assign w_m0_ack   = (r_state == RESP) && !r_owner;
   assign w_m1_ack   = (r_state == RESP) &&  r_owner;

   assign o_m0_ack   = w_m0_ack;
   assign o_m0_err   = w_m0_ack && r_err;
   assign o_m0_rdata = w_m0_ack ? r_rdata : '0;
   assign o_m1_ack   = w_m1_ack;
   assign o_m1_err   = w_m1_ack && r_err;
   assign o_m1_rdata = w_m1_ack ? r_rdata : '0;

   assign o_s_req    = (r_state == ACCESS);
   assign o_s_we     = r_s_we;
   assign o_s_addr   = r_s_addr;
   assign o_s_wdata  = r_s_wdata;
   assign o_s_size   = r_s_size;
   assign o_busy     = (r_state != IDLE);
   assign o_owner    = r_owner;

endmodule
`default_nettype wire
